// File: rtl/gcn_phase_ctrl.sv
// gcn_phase_ctrl: top-level sequencer for the GCN inference datapath.
// One start pulse runs the whole inference:
//   LOAD      sweeps the feature/weight read addresses and launches
//             feature transform plus COO-to-adjacency conversion;
//   WAIT_DEP  waits for both of those stages to complete;
//   WAIT_AGG  runs aggregation;
//   WAIT_MAX  runs arg-max/writeback;
//   DONE      pulses done for one cycle.
// Each wait state has a watchdog, so a stalled stage aborts the run with err
// instead of hanging the block.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      run request, only sampled in IDLE
//   trans_d, coo_adj_done      transform / adjacency complete (pulse or level)
//   agg_d, max_done            aggregation / arg-max complete
//   input_re                   feature/weight memory read enable
//   input_addr_fm_row          feature row address (inner loop)
//   input_addr_wm              weight row address (outer loop)
//   trans_start, conv_start    one-cycle launches in the first LOAD cycle
//   agg_start, max_start       one-cycle launches on entering WAIT_AGG / WAIT_MAX
//   busy                       high whenever the sequencer is not IDLE
//   done                       one-cycle run-complete pulse
//   err                        sticky watchdog abort flag
//
// All outputs are registered. Each one is loaded from the value it will have
// in the state being entered, so a launch pulse lines up with the first cycle
// of its state.
module gcn_phase_ctrl #(
  parameter int unsigned NUM_FM_ROWS = 6,
  parameter int unsigned NUM_WM_ROWS = 3,
  parameter int unsigned FM_AW       = 3,
  parameter int unsigned WM_AW       = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             trans_d,
  input  logic             coo_adj_done,
  input  logic             agg_d,
  input  logic             max_done,
  output logic             input_re,
  output logic [FM_AW-1:0] input_addr_fm_row,
  output logic [WM_AW-1:0] input_addr_wm,
  output logic             trans_start,
  output logic             conv_start,
  output logic             agg_start,
  output logic             max_start,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned WD_W = 16;

  // Last address of each sweep loop.
  localparam logic [FM_AW-1:0] FM_LAST = FM_AW'(NUM_FM_ROWS - 1);
  localparam logic [WM_AW-1:0] WM_LAST = WM_AW'(NUM_WM_ROWS - 1);

  // Abort fires in the wait cycle whose increment would bring the counter to
  // TIMEOUT, so a stage gets exactly TIMEOUT cycles in its wait state.
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WAIT_DEP = 3'd2,
    S_WAIT_AGG = 3'd3,
    S_WAIT_MAX = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  // Next-cycle values of the registered outputs and internal state.
  logic [FM_AW-1:0] fm_d;
  logic [WM_AW-1:0] wm_d;
  logic             re_d;
  logic             trans_start_d;
  logic             conv_start_d;
  logic             agg_start_d;
  logic             max_start_d;
  logic             busy_d;
  logic             done_d;
  logic             err_d;

  // Completion flags for the two upstream stages. They can finish while the
  // address sweep is still running, so each completion is remembered here.
  logic             trans_seen_q;
  logic             trans_seen_d;
  logic             conv_seen_q;
  logic             conv_seen_d;

  logic [WD_W-1:0]  wd_cnt_q;
  logic [WD_W-1:0]  wd_cnt_d;

  // Wait-state exit conditions and watchdog expiry.
  logic             dep_ok;
  logic             wd_expired;
  logic             in_wait;

  // Remembered or same-cycle completion both satisfy the dependency, so a
  // completion that arrives in the WAIT_DEP cycle itself is not lost.
  assign dep_ok     = (trans_seen_q | trans_d) & (conv_seen_q | coo_adj_done);
  assign wd_expired = (wd_cnt_q == WD_LAST);
  assign in_wait    = (state_q == S_WAIT_DEP) || (state_q == S_WAIT_AGG) ||
                      (state_q == S_WAIT_MAX);

  // Next-state, next-output and counter logic.
  always_comb begin
    state_d       = state_q;
    fm_d          = '0;
    wm_d          = '0;
    re_d          = 1'b0;
    trans_start_d = 1'b0;
    conv_start_d  = 1'b0;
    agg_start_d   = 1'b0;
    max_start_d   = 1'b0;
    err_d         = err;
    // Completions are only remembered while a run is in progress; anything
    // arriving in IDLE is stale and dropped.
    trans_seen_d  = trans_seen_q | ((state_q != S_IDLE) & trans_d);
    conv_seen_d   = conv_seen_q  | ((state_q != S_IDLE) & coo_adj_done);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD;
          re_d          = 1'b1;
          trans_start_d = 1'b1;
          conv_start_d  = 1'b1;
          err_d         = 1'b0;
          trans_seen_d  = 1'b0;
          conv_seen_d   = 1'b0;
        end
      end

      // Weight row outer, feature row inner, one address per cycle.
      S_LOAD: begin
        re_d = 1'b1;
        if (input_addr_fm_row == FM_LAST) begin
          fm_d = '0;
          if (input_addr_wm == WM_LAST) begin
            state_d = S_WAIT_DEP;
            re_d    = 1'b0;
            wm_d    = '0;
          end else begin
            wm_d = input_addr_wm + WM_AW'(1);
          end
        end else begin
          fm_d = input_addr_fm_row + FM_AW'(1);
          wm_d = input_addr_wm;
        end
      end

      S_WAIT_DEP: begin
        if (dep_ok) begin
          state_d     = S_WAIT_AGG;
          agg_start_d = 1'b1;
        end else if (wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      S_WAIT_AGG: begin
        if (agg_d) begin
          state_d     = S_WAIT_MAX;
          max_start_d = 1'b1;
        end else if (wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      S_WAIT_MAX: begin
        if (max_done) begin
          state_d = S_DONE;
        end else if (wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    // Watchdog restarts on every state change and only counts while waiting.
    if (state_d != state_q || !in_wait) begin
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      input_addr_fm_row <= '0;
      input_addr_wm     <= '0;
      input_re          <= 1'b0;
      trans_start       <= 1'b0;
      conv_start        <= 1'b0;
      agg_start         <= 1'b0;
      max_start         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      trans_seen_q      <= 1'b0;
      conv_seen_q       <= 1'b0;
      wd_cnt_q          <= '0;
    end else begin
      state_q           <= state_d;
      input_addr_fm_row <= fm_d;
      input_addr_wm     <= wm_d;
      input_re          <= re_d;
      trans_start       <= trans_start_d;
      conv_start        <= conv_start_d;
      agg_start         <= agg_start_d;
      max_start         <= max_start_d;
      busy              <= busy_d;
      done              <= done_d;
      err               <= err_d;
      trans_seen_q      <= trans_seen_d;
      conv_seen_q       <= conv_seen_d;
      wd_cnt_q          <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_gcn_phase_ctrl.sv
// Directed testbench for gcn_phase_ctrl at default parameters
// (6 feature rows, 3 weight rows, TIMEOUT 64).
// Cycle c means the clock period after the c-th rising edge of a scenario.
// Inputs for cycle c are driven and the registered outputs are sampled 1 time
// unit after that edge.
module tb_gcn_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       trans_d;
  logic       coo_adj_done;
  logic       agg_d;
  logic       max_done;
  logic       input_re;
  logic [2:0] input_addr_fm_row;
  logic [1:0] input_addr_wm;
  logic       trans_start;
  logic       conv_start;
  logic       agg_start;
  logic       max_start;
  logic       busy;
  logic       done;
  logic       err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected output values for the current cycle.
  logic       e_re;
  logic [1:0] e_wm;
  logic [2:0] e_fm;
  logic       e_ts;
  logic       e_cs;
  logic       e_as;
  logic       e_ms;
  logic       e_busy;
  logic       e_done;
  logic       e_err;

  always #5 clk = ~clk;

  gcn_phase_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .trans_d           (trans_d),
    .coo_adj_done      (coo_adj_done),
    .agg_d             (agg_d),
    .max_done          (max_done),
    .input_re          (input_re),
    .input_addr_fm_row (input_addr_fm_row),
    .input_addr_wm     (input_addr_wm),
    .trans_start       (trans_start),
    .conv_start        (conv_start),
    .agg_start         (agg_start),
    .max_start         (max_start),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  // Field order for both vectors: re wm fm ts cs as ms busy done err.
  function automatic logic [12:0] obs_pack();
    return {input_re, input_addr_wm, input_addr_fm_row, trans_start, conv_start,
            agg_start, max_start, busy, done, err};
  endfunction

  function automatic logic [12:0] exp_pack();
    return {e_re, e_wm, e_fm, e_ts, e_cs, e_as, e_ms, e_busy, e_done, e_err};
  endfunction

  task automatic drive(input logic s, input logic t, input logic c,
                       input logic a, input logic m);
    start        = s;
    trans_d      = t;
    coo_adj_done = c;
    agg_d        = a;
    max_done     = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs in cycle r of a run whose start was in cycle 0:
  // LOAD occupies cycles 1..18 presenting (wm,fm) = ((r-1)/6, (r-1)%6);
  // agg_at, max_at, done_at are the hand-derived launch / completion cycles.
  task automatic exp_run(input int r, input int agg_at, input int max_at,
                         input int done_at);
    e_re   = (r >= 1 && r <= 18);
    e_wm   = e_re ? 2'((r - 1) / 6) : 2'd0;
    e_fm   = e_re ? 3'((r - 1) % 6) : 3'd0;
    e_ts   = (r == 1);
    e_cs   = (r == 1);
    e_as   = (r == agg_at);
    e_ms   = (r == max_at);
    e_busy = (r >= 1 && r <= done_at);
    e_done = (r == done_at);
    e_err  = 1'b0;
  endtask

  task automatic exp_idle();
    exp_run(-5, -1, -1, -1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_idle();
      total_cnt++;
      if (obs_pack() !== exp_pack())
        $display("FAIL reset i=%0d got=%b want=%b", i, obs_pack(), exp_pack());
      else
        pass_cnt++;
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    exp_idle();
    total_cnt++;
    if (obs_pack() !== exp_pack())
      $display("FAIL reset_release got=%b want=%b", obs_pack(), exp_pack());
    else
      pass_cnt++;
  endtask

  // start 0, coo 3, trans 5, agg_d 25, max_done 31 -> agg 20, max 26, done 32.
  task automatic test_nominal();
    for (int c = 0; c <= 35; c++) begin
      drive(c == 0, c == 5, c == 3, c == 25, c == 31);
      exp_run(c, 20, 26, 32);
      total_cnt++;
      if (obs_pack() !== exp_pack())
        $display("FAIL nominal c=%0d got=%b want=%b", c, obs_pack(), exp_pack());
      else
        pass_cnt++;
      tick();
    end
  endtask

  // Same run with start re-asserted mid-LOAD and in the DONE cycle.
  task automatic test_start_ignored();
    int n_done = 0;
    for (int c = 0; c <= 38; c++) begin
      drive(c == 0 || c == 10 || c == 32, c == 5, c == 3, c == 25, c == 31);
      exp_run(c, 20, 26, 32);
      n_done += int'(done);
      total_cnt++;
      if (obs_pack() !== exp_pack())
        $display("FAIL start_busy c=%0d got=%b want=%b", c, obs_pack(), exp_pack());
      else
        pass_cnt++;
      tick();
    end
    total_cnt++;
    if (n_done !== 1)
      $display("FAIL start_busy_done_count got=%0d want=1", n_done);
    else
      pass_cnt++;
  endtask

  // coo_adj_done withheld until cycle 40 -> agg 41, agg_d 45 -> max 46, done 51.
  task automatic test_late_dep();
    for (int c = 0; c <= 53; c++) begin
      drive(c == 0, c == 5, c == 40, c == 45, c == 50);
      exp_run(c, 41, 46, 51);
      total_cnt++;
      if (obs_pack() !== exp_pack())
        $display("FAIL late_dep c=%0d got=%b want=%b", c, obs_pack(), exp_pack());
      else
        pass_cnt++;
      tick();
    end
  endtask

  // agg_d never comes: WAIT_AGG cycles 20..83, abort into IDLE with err at 84.
  // Then a new start at cycle 89 clears err and completes normally.
  task automatic test_watchdog();
    for (int c = 0; c <= 118; c++) begin
      if (c < 89) begin
        drive(c == 0, c == 2, c == 2, 1'b0, 1'b0);
        exp_run(c, 20, -1, 83);
        e_done = 1'b0;
        e_err  = (c >= 84);
      end else begin
        drive(c == 89, c == 91, c == 91, c == 111, c == 115);
        exp_run(c - 89, 20, 23, 27);
        e_err = (c == 89);
      end
      total_cnt++;
      if (obs_pack() !== exp_pack())
        $display("FAIL watchdog c=%0d got=%b want=%b", c, obs_pack(), exp_pack());
      else
        pass_cnt++;
      tick();
    end
  endtask

  // agg_d lands in the 64th and last WAIT_AGG cycle: exit wins, no err.
  task automatic test_watchdog_edge();
    for (int c = 0; c <= 89; c++) begin
      drive(c == 0, c == 2, c == 2, c == 83, c == 86);
      exp_run(c, 20, 84, 87);
      total_cnt++;
      if (obs_pack() !== exp_pack())
        $display("FAIL wd_edge c=%0d got=%b want=%b", c, obs_pack(), exp_pack());
      else
        pass_cnt++;
      tick();
    end
  endtask

  // Reset in cycle 9 drops the run (including the completions seen at 5 and 6);
  // restart at 11 must begin at (0,0) and wait for fresh completions at r=25.
  task automatic test_reset_mid_run();
    for (int c = 0; c <= 45; c++) begin
      rst_n = (c != 9);
      if (c <= 10) begin
        drive(c == 0, c == 5, c == 6, 1'b0, 1'b0);
        if (c <= 9) exp_run(c, -1, -1, 99);
        else        exp_idle();
      end else begin
        drive(c == 11, c == 36, c == 36, c == 39, c == 42);
        exp_run(c - 11, 26, 29, 32);
      end
      total_cnt++;
      if (obs_pack() !== exp_pack())
        $display("FAIL reset_mid c=%0d got=%b want=%b", c, obs_pack(), exp_pack());
      else
        pass_cnt++;
      tick();
    end
    rst_n = 1'b1;
  endtask

  // Run 1 as nominal, run 2 starts in cycle 33 (first IDLE after done).
  // Completions pulsed in the run-2 start cycle are ignored (IDLE) and run-1
  // flags are cleared, so run 2 waits for its own completions at r=30.
  task automatic test_back_to_back();
    for (int c = 0; c <= 76; c++) begin
      if (c < 33) begin
        drive(c == 0, c == 5, c == 3, c == 25, c == 31);
        exp_run(c, 20, 26, 32);
      end else begin
        drive(c == 33, c == 33 || c == 63, c == 33 || c == 63, c == 68, c == 73);
        exp_run(c - 33, 31, 36, 41);
      end
      total_cnt++;
      if (obs_pack() !== exp_pack())
        $display("FAIL back_to_back c=%0d got=%b want=%b", c, obs_pack(), exp_pack());
      else
        pass_cnt++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_nominal();
    test_start_ignored();
    test_late_dep();
    test_watchdog();
    test_watchdog_edge();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
